// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared data memory.
// Port 0 is the core load/store unit, port 1 the debug/DMA agent. One request
// is in flight at a time. It spends one cycle in ACCESS, where the memory
// strobes are driven, and one cycle in RESP, where the registered response goes
// back to the port that issued it. A new request may be accepted during RESP,
// which gives one transaction every two cycles.
module data_memory_arbiter #(
    parameter int ADDR_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_write,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_error,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_write,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_error,

    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    // The word count gets one extra bit so that ADDR_WORDS = 2**30 still fits.
    localparam logic [30:0] ADDR_LIMIT = 31'(ADDR_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    logic        last_grant;   // port granted most recently; 1 after reset so port 0 wins the first tie
    logic        cur_port;
    logic        cur_write;
    logic        cur_error;
    logic [29:0] cur_index;
    logic [31:0] cur_wdata;
    logic [31:0] rdata_q;      // load data captured at the end of ACCESS

    logic        can_accept;
    logic        sel_port;
    logic        handshake;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_error;

    // Pick a port, raise its ready, and decode the selected request payload.
    always_comb begin
        // NOTE: every signal gets a default at the top of an always_comb block, so no path leaves one unassigned and no latch is inferred.
        can_accept = 1'b0;
        sel_port   = 1'b0;
        if (reset_n && (state == IDLE || state == RESP)) begin
            can_accept = 1'b1;
        end
        if (p0_req_valid && p1_req_valid) begin
            sel_port = ~last_grant;
        end else begin
            sel_port = p1_req_valid;
        end

        p0_req_ready = can_accept && p0_req_valid && !sel_port;
        p1_req_ready = can_accept && p1_req_valid &&  sel_port;
        handshake    = p0_req_ready || p1_req_ready;

        sel_write = sel_port ? p1_req_write : p0_req_write;
        sel_addr  = sel_port ? p1_req_addr  : p0_req_addr;
        sel_wdata = sel_port ? p1_req_wdata : p0_req_wdata;
        sel_error = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr[31:2]} >= ADDR_LIMIT);
    end

    // Sequence IDLE -> ACCESS -> RESP, latching the accepted request and the load data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_write  <= 1'b0;
            cur_error  <= 1'b0;
            cur_index  <= '0;
            cur_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every register samples the pre-edge values regardless of statement order.
            case (state)
                IDLE, RESP: begin
                    if (handshake) begin
                        state      <= ACCESS;
                        last_grant <= sel_port;
                        cur_port   <= sel_port;
                        cur_write  <= sel_write;
                        cur_error  <= sel_error;
                        cur_index  <= sel_addr[31:2];
                        cur_wdata  <= sel_wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    rdata_q <= (!cur_write && !cur_error) ? mem_read_data : 32'h0;
                    state   <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Drive memory strobes and responses straight from registered state only.
    always_comb begin
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 32'h0;
        mem_write_data   = 32'h0;
        p0_resp_valid    = 1'b0;
        p0_resp_rdata    = 32'h0;
        p0_resp_error    = 1'b0;
        p1_resp_valid    = 1'b0;
        p1_resp_rdata    = 32'h0;
        p1_resp_error    = 1'b0;

        if (state == ACCESS && !cur_error) begin
            mem_read_enable  = !cur_write;
            mem_write_enable =  cur_write;
            mem_address      = {2'b00, cur_index};
            mem_write_data   = cur_wdata;
        end

        if (state == RESP) begin
            if (cur_port) begin
                p1_resp_valid = 1'b1;
                p1_resp_rdata = rdata_q;
                p1_resp_error = cur_error;
            end else begin
                p0_resp_valid = 1'b1;
                p0_resp_rdata = rdata_q;
                p0_resp_error = cur_error;
            end
        end
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer for the shared data memory. It accepts word load/store requests from the core load/store unit on port 0 and from a debug/DMA agent on port 1. It grants one request at a time using round-robin and drives the memory's read/write enables, word address and write data for exactly one cycle. It returns a registered response with read data or an error flag to the requester that issued the request.

## Interface
Parameters:
- ADDR_WORDS, 1024, number of 32-bit words in the memory; word indices at or above this value are errors.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low; clears all state.
- p0_req_valid / p1_req_valid  input  1  request present on port 0 / port 1.
- p0_req_ready / p1_req_ready  output  1  request accepted this cycle.
- p0_req_write / p1_req_write  input  1  1 = store, 0 = load.
- p0_req_addr / p1_req_addr  input  32  byte address.
- p0_req_wdata / p1_req_wdata  input  32  store data.
- p0_resp_valid / p1_resp_valid  output  1  one-cycle response pulse.
- p0_resp_rdata / p1_resp_rdata  output  32  load data; 0 for stores and errors.
- p0_resp_error / p1_resp_error  output  1  misaligned or out-of-range request.
- mem_read_enable  output  1  memory read strobe.
- mem_write_enable  output  1  memory write strobe.
- mem_address  output  32  word index, equal to byte address >> 2.
- mem_write_data  output  32  store data to the memory.
- mem_read_data  input  32  combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Acceptance:
  - req_ready is asserted only in IDLE or RESP, and only to the selected port.
  - Selection: if one port is valid, that port is selected. If both are valid, the port not granted last is selected.
  - last_grant resets to 1, so port 0 wins the first tie.
  - ready is combinational from valid and state. A handshake (valid & ready) latches port id, write, word index (addr[31:2]), wdata and an error flag. The FSM then goes to ACCESS, and last_grant is updated.
- Error flag: set when addr[1:0] != 0 or addr[31:2] >= ADDR_WORDS.
- ACCESS, one cycle:
  - No error: mem_read_enable = !write, mem_write_enable = write, mem_address = latched index, mem_write_data = latched wdata.
  - Error: both enables stay 0.
  - For a load, mem_read_data is captured at the closing edge. The FSM then goes to RESP.
- RESP, one cycle:
  - The granted port's resp_valid = 1, with resp_rdata = captured data (0 for stores and errors) and resp_error = latched flag.
  - The other port's response outputs stay 0.
  - If a new handshake occurs in this cycle, the FSM goes to ACCESS; otherwise it goes to IDLE.
- Responses have no backpressure. A requester must accept resp_valid in the cycle it is asserted.
- Outside ACCESS:
  - mem_read_enable = mem_write_enable = 0.
  - mem_address = 0 and mem_write_data = 0.
  - All resp_* outputs are 0 except during RESP.
- Requesters hold valid and payload stable until ready; the arbiter does not buffer unaccepted requests.

## Timing
- Reset (reset_n low, any time, asynchronous):
  - FSM returns to IDLE and last_grant = 1.
  - All outputs are 0: ready, resp_*, mem_* enables, address and write data.
  - An in-flight transaction is dropped: no memory strobe and no response after reset is released.
- Handshake at edge N: ACCESS is the cycle N..N+1. The store is written by the memory at edge N+1. resp_valid is high in cycle N+1..N+2.
- Latency is 2 cycles from acceptance to response.
- Back-to-back throughput is one transaction per 2 cycles, with acceptance in RESP overlapping the previous response.
- Ready is never asserted in ACCESS.
- Simultaneous requests alternate strictly. A port cannot be starved for more than one transaction.
- A store followed by a load to the same address, from either port, returns the stored data, because the write completes before the next ACCESS.

## Test plan
- Reset, then p0 store addr 0x10, data 0xDEADBEEF, then p0 load addr 0x10:
  - Store: mem_write_enable high for 1 cycle with mem_address = 4.
  - Load: resp_valid 2 cycles after acceptance with rdata = 0xDEADBEEF and error = 0.
- p0 and p1 both hold valid loads for 4 transactions:
  - Grants are p0, p1, p0, p1, with accept every 2 cycles and never two ready in the same cycle.
- p1 load addr 0x13 and p1 load addr 0x1000 (index 1024):
  - Each gets resp_error = 1 and rdata = 0.
  - mem_read_enable and mem_write_enable stay 0 throughout.
- p0 store accepted, reset_n pulsed low during ACCESS:
  - All outputs are 0 immediately.
  - No resp_valid follows.
  - First request after release goes to p0 on a tie.
- p1 store addr 0x8, data 0x1234, back-to-back with p0 load addr 0x8 accepted in the RESP cycle:
  - p0 response rdata = 0x00001234.
- Idle bench with no valids for 10 cycles:
  - All mem_* and resp_* outputs remain 0.
